// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame from a
// first-word fall-through FIFO and shifts it out start/data/parity/stop.
module fifo_uart_tx #(
    parameter int DATAW     = 8,
    parameter int CLK_DIV   = 868,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [DATAW-1:0] i_rd_data,
    input  logic             i_rd_empty,
    output logic             o_rd_en,
    output logic             o_tx,
    output logic             o_busy
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W  = $clog2(DATAW);

    localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATAW - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam bit                HAS_PAR   = (PARITY != 0);
    localparam bit                ODD_PAR   = (PARITY == 2);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [2:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATAW-1:0]  shift;
    logic              par_bit;
    logic              baud_wrap;

    assign baud_wrap = (baud_cnt == BAUD_MAX);
    assign o_rd_en   = (state == IDLE) & i_en & ~i_rd_empty & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
        end else begin
            if (state != IDLE) begin
                baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (o_rd_en) begin
                        shift    <= i_rd_data;
                        par_bit  <= ODD_PAR ? ~^i_rd_data : ^i_rd_data;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
                        o_tx     <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end
                START: begin
                    // the line register is loaded one bit ahead of the shifter
                    if (baud_wrap) begin
                        state <= DATA;
                        o_tx  <= shift[0];
                        shift <= shift >> 1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (HAS_PAR) begin
                                state <= PAR;
                                o_tx  <= par_bit;
                            end else begin
                                state <= STOP;
                                o_tx  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            o_tx    <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end
                PAR: begin
                    if (baud_wrap) begin
                        state <= STOP;
                        o_tx  <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
